// File: rtl/wta_pkg.sv
// wta_pkg: shared constants and helpers for the 1-WTA inhibition stage.
// Provides counter-width sizing and the lowest-index one-hot selector.
package wta_pkg;

    // Widest spike vector the priority helper handles.
    localparam int WTA_MAX_INPUTS = 64;

    typedef logic [WTA_MAX_INPUTS-1:0] wta_vec_t;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Isolates the lowest set bit: v & -v.
    function automatic wta_vec_t lowest_onehot(input wta_vec_t v);
        return v & (~v + wta_vec_t'(1));
    endfunction

endpackage

// File: rtl/wta_prio_enc.sv
// wta_prio_enc: lowest-index-wins priority encoder for spike vectors.
// Ports: spikes (in), onehot (lowest set bit), valid (any bit set).
module wta_prio_enc
    import wta_pkg::*;
#(
    parameter int NUM_INPUTS = 8
) (
    input  logic [NUM_INPUTS-1:0] spikes,
    output logic [NUM_INPUTS-1:0] onehot,
    output logic                  valid
);

    wta_vec_t ext;
    wta_vec_t oh_ext;

    assign ext    = wta_vec_t'(spikes);
    assign oh_ext = lowest_onehot(ext);
    assign onehot = oh_ext[NUM_INPUTS-1:0];
    // Upper bits of oh_ext are always zero, so this equals |spikes.
    assign valid  = |oh_ext;

endmodule

// File: rtl/wta_1.sv
// wta_1: 1-winner-take-all lateral inhibition over one gamma cycle.
// Ports: clk, rst (async, active-low), input_spikes, output_spikes.
module wta_1
    import wta_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] input_spikes,
    output logic [NUM_INPUTS-1:0] output_spikes
);

    localparam int GW = cnt_width(GAMMA_CYCLE_WIDTH);
    localparam int PW = cnt_width(PULSE_WIDTH + 1);

    localparam logic [GW-1:0] GAMMA_LAST = GW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [GW-1:0] GAMMA_ONE  = GW'(1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_WIDTH);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

    logic [GW-1:0]         gamma_cnt;
    logic [PW-1:0]         pulse_cnt;
    logic                  lock;
    logic [NUM_INPUTS-1:0] prev;
    logic [NUM_INPUTS-1:0] new_spikes;
    logic [NUM_INPUTS-1:0] winner;
    logic                  win_valid;
    logic                  wrap;
    logic                  open;

    assign new_spikes = input_spikes & ~prev;
    assign wrap       = (gamma_cnt == GAMMA_LAST);
    // The wrap edge already belongs to the next gamma cycle.
    assign open       = ~lock | wrap;

    wta_prio_enc #(
        .NUM_INPUTS(NUM_INPUTS)
    ) u_prio (
        .spikes(new_spikes),
        .onehot(winner),
        .valid (win_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gamma_cnt     <= '0;
            pulse_cnt     <= '0;
            lock          <= 1'b0;
            prev          <= '0;
            output_spikes <= '0;
        end else begin
            prev      <= input_spikes;
            gamma_cnt <= wrap ? '0 : gamma_cnt + GAMMA_ONE;
            if (open && win_valid) begin
                output_spikes <= winner;
                lock          <= 1'b1;
                pulse_cnt     <= PULSE_LOAD;
            end else if (wrap) begin
                output_spikes <= '0;
                lock          <= 1'b0;
                pulse_cnt     <= '0;
            end else if (pulse_cnt == PULSE_ONE) begin
                output_spikes <= '0;
                pulse_cnt     <= '0;
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - PULSE_ONE;
            end
        end
    end

endmodule

// File: tb/tb_wta_1.sv
// tb_wta_1: directed self-checking bench for wta_1.
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_wta_1;

    logic       clk;
    logic       rst;
    logic [7:0] input_spikes;
    logic [7:0] output_spikes;

    int n_checks;
    int n_fails;

    wta_1 #(
        .GAMMA_CYCLE_WIDTH(16),
        .PULSE_WIDTH      (8),
        .NUM_INPUTS       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_spikes (input_spikes),
        .output_spikes(output_spikes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        n_checks++;
        assert (output_spikes === exp)
        else begin
            n_fails++;
            $error("FAIL %s: output_spikes=%h expected=%h", tag, output_spikes, exp);
        end
    endtask

    // Tick n edges, checking the registered output after each one.
    task automatic hold(input int n, input logic [7:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, exp);
        end
    endtask

    // After this, the next rising edge is edge 0 (gamma count 0 -> 1).
    task automatic do_reset();
        rst = 1'b0;
        input_spikes = '0;
        #2;
        check("reset", 8'h00);
        tick();
        check("reset_held", 8'h00);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b0;
        input_spikes = '0;
        #1;

        // Single spike, held high; re-spike of the winner is inhibited.
        do_reset();
        hold(2, 8'h00, "single_pre");
        input_spikes = 8'h01;
        hold(8, 8'h01, "single_pulse");
        hold(1, 8'h00, "single_end");
        input_spikes = 8'h00;
        hold(1, 8'h00, "single_drop");
        input_spikes = 8'h01;
        hold(11, 8'h00, "single_respike");

        // Staggered arrivals: bit 3 first.
        do_reset();
        input_spikes = 8'h08;
        hold(1, 8'h08, "stag_a");
        input_spikes = 8'h88;
        hold(1, 8'h08, "stag_b");
        input_spikes = 8'hC8;
        hold(2, 8'h08, "stag_c");
        input_spikes = 8'hCC;
        hold(4, 8'h08, "stag_d");
        hold(7, 8'h00, "stag_end");

        // Simultaneous arrivals: lowest index wins.
        do_reset();
        input_spikes = 8'h31;
        hold(1, 8'h01, "simul_a");
        input_spikes = 8'h71;
        hold(2, 8'h01, "simul_b");
        input_spikes = 8'h75;
        hold(5, 8'h01, "simul_c");
        hold(7, 8'h00, "simul_end");

        // Gamma rollover: counts name the value the sampling edge loads.
        do_reset();
        hold(2, 8'h00, "roll_pre");
        input_spikes = 8'h02;
        hold(8, 8'h02, "roll_first");
        hold(3, 8'h00, "roll_gap");
        input_spikes = 8'h12;
        hold(4, 8'h00, "roll_inhibit");
        input_spikes = 8'h32;
        hold(8, 8'h20, "roll_second");
        hold(5, 8'h00, "roll_end");

        // Truncation: pulse cut off at the wrap edge after 4 clocks.
        do_reset();
        hold(11, 8'h00, "trunc_pre");
        input_spikes = 8'h04;
        hold(4, 8'h04, "trunc_pulse");
        hold(3, 8'h00, "trunc_cut");

        // Asynchronous reset mid-pulse, bit 7 held through release.
        do_reset();
        input_spikes = 8'h04;
        hold(3, 8'h04, "async_pre");
        rst = 1'b0;
        input_spikes = 8'h80;
        #2;
        check("async_clear", 8'h00);
        #1;
        rst = 1'b1;
        hold(8, 8'h80, "async_pulse");
        hold(4, 8'h00, "async_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
